// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - GPIO register map shared with the memory controller decode
package gpio_pkg;

    localparam int GPIO_ADDR_W = 3;

    localparam logic [GPIO_ADDR_W-1:0] GPIO_LEDS     = 3'd0;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_SW       = 3'd1;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_SW_CHG   = 3'd2;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_SW_RAW   = 3'd3;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_IRQ_MASK = 3'd4;

endpackage

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - one switch bit: 2-FF synchroniser, debounce counter, toggle pulse
module sw_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sw,
    output logic o_raw,
    output logic o_deb,
    output logic o_toggle
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_deb;
    logic [CW-1:0] r_cnt;
    logic          w_diff;

    assign w_diff   = r_sync2 ^ r_deb;
    // High on the cycle whose closing edge flips r_deb, so SW_CHG sets on that same edge
    assign o_toggle = w_diff && (r_cnt == CNT_MAX);
    assign o_raw    = r_sync2;
    assign o_deb    = r_deb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_sw;
            r_sync2 <= r_sync1;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_deb <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/gpio_sw_led_periph.sv
// rtl/gpio_sw_led_periph.sv - LED/switch GPIO peripheral with sticky change status and level IRQ
module gpio_sw_led_periph
    import gpio_pkg::*;
#(
    parameter int N_SW       = 8,
    parameter int N_LED      = 8,
    parameter int DEB_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   gpio_en,
    input  logic                   gpio_we,
    input  logic [GPIO_ADDR_W-1:0] gpio_addr,
    input  logic [31:0]            gpio_wdata,
    output logic [31:0]            gpio_rdata,
    input  logic [N_SW-1:0]        switches,
    output logic [N_LED-1:0]       leds,
    output logic                   sw_irq
);

    logic [N_LED-1:0] r_leds;
    logic [N_SW-1:0]  r_mask;
    logic [N_SW-1:0]  r_chg;
    logic             r_irq;

    logic [N_SW-1:0]  w_raw;
    logic [N_SW-1:0]  w_deb;
    logic [N_SW-1:0]  w_tog;
    logic [N_SW-1:0]  w_clr;
    logic [N_SW-1:0]  w_chg_next;
    logic             w_wr;
    logic [31:0]      w_rdata;
    logic             w_unused_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < N_SW; gi++) begin : g_sw
            sw_debounce #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_deb (
                .clk     (clk),
                .rst     (rst),
                .i_sw    (switches[gi]),
                .o_raw   (w_raw[gi]),
                .o_deb   (w_deb[gi]),
                .o_toggle(w_tog[gi])
            );
        end
    endgenerate

    assign w_wr           = gpio_en & gpio_we;
    assign w_clr          = (w_wr && gpio_addr == GPIO_SW_CHG) ? gpio_wdata[N_SW-1:0] : '0;
    // OR-ing the toggle after the clear makes a same-cycle event win over W1C
    assign w_chg_next     = (r_chg & ~w_clr) | w_tog;
    assign w_unused_wdata = ^gpio_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_leds <= '0;
            r_mask <= '0;
            r_chg  <= '0;
            r_irq  <= 1'b0;
        end else begin
            if (w_wr && gpio_addr == GPIO_LEDS) begin
                r_leds <= gpio_wdata[N_LED-1:0];
            end
            if (w_wr && gpio_addr == GPIO_IRQ_MASK) begin
                r_mask <= gpio_wdata[N_SW-1:0];
            end
            r_chg <= w_chg_next;
            r_irq <= |(r_chg & r_mask);
        end
    end

    always_comb begin
        w_rdata = '0;
        if (gpio_en && !gpio_we) begin
            case (gpio_addr)
                GPIO_LEDS:     w_rdata[N_LED-1:0] = r_leds;
                GPIO_SW:       w_rdata[N_SW-1:0]  = w_deb;
                GPIO_SW_CHG:   w_rdata[N_SW-1:0]  = r_chg;
                GPIO_SW_RAW:   w_rdata[N_SW-1:0]  = w_raw;
                GPIO_IRQ_MASK: w_rdata[N_SW-1:0]  = r_mask;
                default:       w_rdata            = '0;
            endcase
        end
    end

    assign gpio_rdata = w_rdata;
    assign leds       = r_leds;
    assign sw_irq     = r_irq;

endmodule

// File: tb/tb_gpio_sw_led_periph.sv
// tb/tb_gpio_sw_led_periph.sv - self-checking bench with a window-based reference model
`timescale 1ns/1ps
module tb_gpio_sw_led_periph;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        gpio_en = 1'b0;
    logic        gpio_we = 1'b0;
    logic [2:0]  gpio_addr = 3'd0;
    logic [31:0] gpio_wdata = 32'h0;
    logic [31:0] gpio_rdata;
    logic [7:0]  switches = 8'h00;
    logic [7:0]  leds;
    logic        sw_irq;

    int checks = 0;
    int failures = 0;

    gpio_sw_led_periph #(.N_SW(8), .N_LED(8), .DEB_CYCLES(DEB)) dut (
        .clk       (clk),
        .rst       (rst),
        .gpio_en   (gpio_en),
        .gpio_we   (gpio_we),
        .gpio_addr (gpio_addr),
        .gpio_wdata(gpio_wdata),
        .gpio_rdata(gpio_rdata),
        .switches  (switches),
        .leds      (leds),
        .sw_irq    (sw_irq)
    );

    always #5 clk = ~clk;

    // Reference model: a bit is accepted once the last DEB synchronised samples all disagree with it
    logic [7:0] m_leds = 0, m_mask = 0, m_chg = 0, m_deb = 0, m_s1 = 0, m_s2 = 0;
    logic       m_irq = 0;
    logic [7:0] q_raw[$];

    always @(posedge clk) begin
        logic [7:0] nd;
        logic [7:0] clr;
        logic       all_diff;
        if (rst) begin
            m_leds = 0; m_mask = 0; m_chg = 0; m_deb = 0; m_s1 = 0; m_s2 = 0; m_irq = 0;
            q_raw.delete();
        end else begin
            q_raw.push_back(m_s2);
            if (q_raw.size() > DEB) void'(q_raw.pop_front());
            nd = m_deb;
            if (q_raw.size() == DEB) begin
                for (int b = 0; b < 8; b++) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < DEB; j++)
                        if (q_raw[j][b] == m_deb[b]) all_diff = 1'b0;
                    if (all_diff) nd[b] = ~m_deb[b];
                end
            end
            m_irq = |(m_chg & m_mask);
            clr = 8'h00;
            if (gpio_en && gpio_we) begin
                case (gpio_addr)
                    3'd0: m_leds = gpio_wdata[7:0];
                    3'd2: clr = gpio_wdata[7:0];
                    3'd4: m_mask = gpio_wdata[7:0];
                    default: ;
                endcase
            end
            m_chg = (m_chg & ~clr) | (nd ^ m_deb);
            m_deb = nd;
            m_s2  = m_s1;
            m_s1  = switches;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [2:0] a);
        case (a)
            3'd0: return {24'h0, m_leds};
            3'd1: return {24'h0, m_deb};
            3'd2: return {24'h0, m_chg};
            3'd3: return {24'h0, m_s2};
            3'd4: return {24'h0, m_mask};
            default: return 32'h0;
        endcase
    endfunction

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        gpio_en = 1; gpio_we = 1; gpio_addr = a; gpio_wdata = d;
        @(negedge clk);
        gpio_en = 0; gpio_we = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        checks++;
        if (leds !== 8'h00 || sw_irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_out leds=%h irq=%b exp leds=00 irq=0", leds, sw_irq);
        end
        for (int a = 0; a < 8; a++) begin
            @(negedge clk);
            gpio_en = 1; gpio_we = 0; gpio_addr = 3'(a);
            #1;
            checks++;
            if (gpio_rdata !== 32'h0) begin
                failures++;
                $display("FAIL reset_rd a=%0d got=%h exp=00000000", a, gpio_rdata);
            end
        end
        gpio_en = 0;
    endtask

    task automatic test_leds;
        logic [31:0] d;
        bus_wr(3'd0, 32'h0000_00A5);
        gpio_en = 1; gpio_we = 0; gpio_addr = 3'd0;
        #1;
        checks++;
        if (leds !== 8'hA5 || gpio_rdata !== 32'h0000_00A5) begin
            failures++;
            $display("FAIL leds_a5 leds=%h rd=%h exp A5/000000A5", leds, gpio_rdata);
        end
        gpio_en = 0;
        for (int i = 0; i < 6; i++) begin
            d = $urandom;
            bus_wr(3'(i % 2 == 0 ? 0 : 1 + 4 * (i % 3 == 0 ? 1 : 0)), d);
            gpio_en = 1; gpio_we = 0; gpio_addr = 3'd0;
            #1;
            checks++;
            if (leds !== m_leds || gpio_rdata !== exp_rd(3'd0)) begin
                failures++;
                $display("FAIL leds_rand i=%0d leds=%h rd=%h exp=%h", i, leds, gpio_rdata, m_leds);
            end
            gpio_en = 0;
        end
        bus_wr(3'd7, 32'hFFFF_FFFF);
        gpio_en = 1; gpio_we = 0; gpio_addr = 3'd7;
        #1;
        checks++;
        if (gpio_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rd_unmapped got=%h exp=00000000", gpio_rdata);
        end
        gpio_en = 0;
    endtask

    task automatic test_switch_latency;
        @(negedge clk);
        switches = 8'h0F;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            gpio_en = 1; gpio_we = 0; gpio_addr = 3'd3;
            #1;
            checks++;
            if (gpio_rdata !== (k >= 2 ? 32'h0F : 32'h0) || gpio_rdata !== exp_rd(3'd3)) begin
                failures++;
                $display("FAIL sw_raw_lat k=%0d got=%h model=%h", k, gpio_rdata, exp_rd(3'd3));
            end
            gpio_addr = 3'd1;
            #1;
            checks++;
            if (gpio_rdata !== (k >= 6 ? 32'h0F : 32'h0) || gpio_rdata !== exp_rd(3'd1)) begin
                failures++;
                $display("FAIL sw_deb_lat k=%0d got=%h model=%h", k, gpio_rdata, exp_rd(3'd1));
            end
        end
        gpio_addr = 3'd2;
        #1;
        checks++;
        if (gpio_rdata !== 32'h0F) begin
            failures++;
            $display("FAIL sw_chg_set got=%h exp=0000000f", gpio_rdata);
        end
        gpio_en = 0;
        bus_wr(3'd2, 32'h0000_000F);
    endtask

    task automatic test_glitch;
        bit saw = 0;
        @(negedge clk);
        switches[7] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k == 3) switches[7] = 1'b0;
            @(negedge clk);
            gpio_en = 1; gpio_we = 0; gpio_addr = 3'd3;
            #1;
            if (gpio_rdata[7]) saw = 1;
            gpio_addr = 3'd1;
            #1;
            checks++;
            if (gpio_rdata[7] !== 1'b0 || gpio_rdata !== exp_rd(3'd1)) begin
                failures++;
                $display("FAIL glitch_sw k=%0d got=%h model=%h", k, gpio_rdata, exp_rd(3'd1));
            end
            gpio_addr = 3'd2;
            #1;
            checks++;
            if (gpio_rdata[7] !== 1'b0 || gpio_rdata !== exp_rd(3'd2)) begin
                failures++;
                $display("FAIL glitch_chg k=%0d got=%h model=%h", k, gpio_rdata, exp_rd(3'd2));
            end
        end
        gpio_en = 0;
        checks++;
        if (!saw) begin
            failures++;
            $display("FAIL glitch_raw_seen got=0 exp=1");
        end
    endtask

    task automatic test_irq;
        int chg_at = -1;
        int irq_at = -1;
        bus_wr(3'd4, 32'h0000_0001);
        switches[0] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            gpio_en = 1; gpio_we = 0; gpio_addr = 3'd2;
            #1;
            if (chg_at < 0 && gpio_rdata[0]) chg_at = k;
            if (irq_at < 0 && sw_irq) irq_at = k;
            checks++;
            if (sw_irq !== m_irq || gpio_rdata !== exp_rd(3'd2)) begin
                failures++;
                $display("FAIL irq_track k=%0d irq=%b chg=%h exp irq=%b chg=%h",
                         k, sw_irq, gpio_rdata, m_irq, exp_rd(3'd2));
            end
        end
        gpio_en = 0;
        checks++;
        if (chg_at < 0 || irq_at != chg_at + 1) begin
            failures++;
            $display("FAIL irq_lag chg_at=%0d irq_at=%0d exp irq_at=chg_at+1", chg_at, irq_at);
        end
        bus_wr(3'd2, 32'h0000_0001);
        gpio_en = 1; gpio_we = 0; gpio_addr = 3'd2;
        #1;
        checks++;
        if (gpio_rdata[0] !== 1'b0 || sw_irq !== m_irq) begin
            failures++;
            $display("FAIL irq_w1c chg=%h irq=%b exp chg0=0 irq=%b", gpio_rdata, sw_irq, m_irq);
        end
        @(negedge clk);
        checks++;
        if (sw_irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_clear irq=%b exp=0", sw_irq);
        end
        gpio_en = 0;
    endtask

    task automatic test_back_to_back;
        bus_wr(3'd2, 32'h0000_00FF);
        @(negedge clk);
        switches[1] = 1'b0;
        repeat (5) @(negedge clk);
        gpio_en = 1; gpio_we = 1; gpio_addr = 3'd2; gpio_wdata = 32'h0000_0002;
        @(negedge clk);
        gpio_we = 0;
        #1;
        checks++;
        if (gpio_rdata[1] !== 1'b1 || gpio_rdata !== exp_rd(3'd2)) begin
            failures++;
            $display("FAIL set_wins chg=%h model=%h exp bit1=1", gpio_rdata, exp_rd(3'd2));
        end
        gpio_addr = 3'd1;
        #1;
        checks++;
        if (gpio_rdata[1] !== 1'b0) begin
            failures++;
            $display("FAIL set_wins_deb sw=%h exp bit1=0", gpio_rdata);
        end
        gpio_en = 0;
    endtask

    task automatic test_random;
        int hold = 0;
        int op;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            checks++;
            if (leds !== m_leds || sw_irq !== m_irq) begin
                failures++;
                $display("FAIL rand_out c=%0d leds=%h irq=%b exp leds=%h irq=%b",
                         c, leds, sw_irq, m_leds, m_irq);
            end
            if (hold == 0) begin
                switches = (switches ^ 8'($urandom_range(0, 255) & $urandom_range(0, 255)));
                hold = $urandom_range(1, 9);
            end else begin
                hold--;
            end
            op = $urandom_range(0, 3);
            gpio_en = (op != 0);
            gpio_we = (op == 3);
            gpio_addr = 3'($urandom_range(0, 7));
            gpio_wdata = $urandom;
            #1;
            checks++;
            if (gpio_rdata !== ((op == 1 || op == 2) ? exp_rd(gpio_addr) : 32'h0)) begin
                failures++;
                $display("FAIL rand_rd c=%0d a=%0d got=%h exp=%h", c, gpio_addr, gpio_rdata,
                         (op == 1 || op == 2) ? exp_rd(gpio_addr) : 32'h0);
            end
        end
        @(negedge clk);
        gpio_en = 0; gpio_we = 0;
    endtask

    task automatic test_reset_mid;
        logic [7:0] v;
        v = 8'($urandom);
        @(negedge clk);
        switches = v;
        repeat (12) @(negedge clk);
        switches = ~v;
        repeat (4) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        checks++;
        if (leds !== 8'h00 || sw_irq !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_out leds=%h irq=%b exp 00/0", leds, sw_irq);
        end
        for (int a = 0; a < 5; a++) begin
            gpio_en = 1; gpio_we = 0; gpio_addr = 3'(a);
            #0.5;
            checks++;
            if (gpio_rdata !== 32'h0) begin
                failures++;
                $display("FAIL rstmid_rd a=%0d got=%h exp=00000000", a, gpio_rdata);
            end
        end
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            gpio_addr = 3'd1;
            #1;
            checks++;
            if (gpio_rdata !== (k >= 2 + DEB ? {24'h0, ~v} : 32'h0) || gpio_rdata !== exp_rd(3'd1)) begin
                failures++;
                $display("FAIL rstmid_lat k=%0d got=%h model=%h", k, gpio_rdata, exp_rd(3'd1));
            end
        end
        gpio_addr = 3'd5;
        #1;
        checks++;
        if (gpio_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rd_off5 got=%h exp=00000000", gpio_rdata);
        end
        gpio_en = 0;
    endtask

    initial begin
        test_reset();
        test_leds();
        test_switch_latency();
        test_glitch();
        test_irq();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
